reg_bank_8x4: RTL and testbench



---
 rtl/reg_bank_8x4_pkg.sv | 19 +
 rtl/reg_bank_8x4_mux.sv | 17 +
 rtl/reg_bank_8x4.sv | 104 ++++++++++
 tb/tb_reg_bank_8x4.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_8x4_pkg.sv
`default_nettype none
// ============================================================================
// reg_bank_8x4_pkg : shared sizes and FSM state type for the 8x4 register bank
// Revision: 1.0
// ============================================================================
package reg_bank_8x4_pkg;

  localparam int N_ENTRIES = 8;
  localparam int WIDTH     = 4;
  localparam int SEL_W     = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } bank_state_t;

endpackage : reg_bank_8x4_pkg
`default_nettype wire

// File: rtl/reg_bank_8x4_mux.sv
`default_nettype none
// ============================================================================
// mux_8x4_3 : 8:1 x 4-bit read mux, the mirror of the upstream write demux
// Revision: 1.0
// ============================================================================
module mux_8x4_3
  import reg_bank_8x4_pkg::*;
(
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] d,
  input  logic [SEL_W-1:0]                sel,
  output logic [WIDTH-1:0]                y
);

  assign y = d[sel];

endmodule : mux_8x4_3
`default_nettype wire

// File: rtl/reg_bank_8x4.sv
`default_nettype none
// ============================================================================
// reg_bank_8x4 : 8-entry x 4-bit register bank with valid flags, occupancy
//                count and a one-entry-per-cycle clear sweep
// Revision: 1.0
// ============================================================================
module reg_bank_8x4
  import reg_bank_8x4_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] D,
  input  logic [SEL_W-1:0]                wr_sel,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [SEL_W-1:0]                rd_sel,
  output logic [WIDTH-1:0]                rd_data,
  output logic                            rd_hit,
  input  logic                            clr_req,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic [SEL_W:0]                  count
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_ENTRIES - 1);

  logic [N_ENTRIES-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [N_ENTRIES-1:0]            valid_q, valid_d;
  logic [SEL_W:0]                  count_q, count_d;
  logic [SEL_W-1:0]                idx_q, idx_d;
  bank_state_t                     state_q, state_d;
  logic                            wr_ready_q, clr_busy_q, clr_done_q;
  logic                            wr_accept;

  // wr_ready_q is high exactly when the bank sits in IDLE
  assign wr_accept = wr_valid && wr_ready_q;

  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    count_d = count_q;
    idx_d   = idx_q;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_accept) begin
          regs_d[wr_sel]  = D[wr_sel];
          valid_d[wr_sel] = 1'b1;
          if (!valid_q[wr_sel]) count_d = count_q + 1'b1;
        end
        // a same-cycle write still lands; the sweep will clear it later
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[idx_q]  = '0;
        valid_d[idx_q] = 1'b0;
        if (valid_q[idx_q]) count_d = count_q - 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      state_q    <= IDLE;
      wr_ready_q <= 1'b1;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      wr_ready_q <= (state_d == IDLE);
      clr_busy_q <= (state_d == CLEAR);
      clr_done_q <= (state_d == DONE);
    end
  end

  mux_8x4_3 u_rd_mux (
    .d   (regs_q),
    .sel (rd_sel),
    .y   (rd_data)
  );

  assign rd_hit   = valid_q[rd_sel];
  assign wr_ready = wr_ready_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign count    = count_q;

endmodule : reg_bank_8x4
`default_nettype wire

// File: tb/tb_reg_bank_8x4.sv
`default_nettype none
// ============================================================================
// tb_reg_bank_8x4 : directed + randomized bench against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_reg_bank_8x4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0][3:0] D;
  logic [2:0]      wr_sel;
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      rd_sel;
  logic [3:0]      rd_data;
  logic            rd_hit;
  logic            clr_req;
  logic            clr_busy;
  logic            clr_done;
  logic [3:0]      count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: contents, flags and a phase/sweep position
  logic [3:0] m_regs [8];
  bit         m_valid[8];
  int         m_phase;   // 0 idle, 1 sweeping, 2 done pulse
  int         m_pos;

  reg_bank_8x4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D        (D),
    .wr_sel   (wr_sel),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .count    (count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i]  = 4'h0;
      m_valid[i] = 1'b0;
    end
    m_phase = 0;
    m_pos   = 0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    case (m_phase)
      0: begin
        if (wr_valid) begin
          m_regs[wr_sel]  = D[wr_sel];
          m_valid[wr_sel] = 1'b1;
        end
        if (clr_req) begin
          m_phase = 1;
          m_pos   = 0;
        end
      end
      1: begin
        m_regs[m_pos]  = 4'h0;
        m_valid[m_pos] = 1'b0;
        m_pos++;
        if (m_pos == 8) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  // compare every output, scanning all read addresses (takes 8 ns)
  task automatic check_state(input string tag);
    chk({tag, ".count"},    32'(count),    32'(model_count()));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(m_phase == 0));
    chk({tag, ".clr_busy"}, 32'(clr_busy), 32'(m_phase == 1));
    chk({tag, ".clr_done"}, 32'(clr_done), 32'(m_phase == 2));
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk($sformatf("%s.rd_data[%0d]", tag, i), 32'(rd_data), 32'(m_regs[i]));
      chk($sformatf("%s.rd_hit[%0d]",  tag, i), 32'(rd_hit),  32'(m_valid[i]));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    wr_sel   = 3'd0;
    D        = '0;
  endtask

  task automatic write(input int sel, input logic [3:0] val, input string tag);
    D        = 32'($urandom);   // noise on unused lanes
    D[sel]   = val;
    wr_sel   = 3'(sel);
    wr_valid = 1'b1;
    tick(tag);
    idle_inputs();
  endtask

  initial begin
    rst_n  = 1'b0;
    rd_sel = 3'd0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    #1 check_state("reset");

    // single write with noisy neighbouring lanes; reads see it next cycle
    @(posedge clk); #1;
    write(5, 4'hA, "wr5");

    // fill every entry, then rewrite entry 3
    for (int i = 0; i < 8; i++) write(i, 4'(i + 1), "fill");
    write(3, 4'hF, "rewrite3");
    tick("full_hold");

    // full-bank clear sweep with writes attempted throughout
    clr_req = 1'b1;
    tick("clr_start");
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) begin
      D        = 32'($urandom);
      wr_sel   = 3'($urandom_range(0, 7));
      wr_valid = 1'b1;
      clr_req  = 1'($urandom_range(0, 1));
      tick("sweep");
    end
    idle_inputs();
    tick("post_sweep");

    // write and clear request in the same idle cycle
    D        = '0;
    D[2]     = 4'h6;
    wr_sel   = 3'd2;
    wr_valid = 1'b1;
    clr_req  = 1'b1;
    tick("wr_and_clr");
    idle_inputs();
    for (int c = 0; c < 10; c++) tick("wr_and_clr_sweep");

    // asynchronous reset part-way through a sweep
    for (int i = 0; i < 8; i++) write(i, 4'($urandom), "refill");
    clr_req = 1'b1;
    tick("clr2_start");
    clr_req = 1'b0;
    for (int c = 0; c < 4; c++) tick("clr2_sweep");
    rst_n = 1'b0;
    model_reset();
    #1 check_state("mid_sweep_reset");
    @(posedge clk);
    #5 rst_n = 1'b1;
    #1;
    chk("post_reset.wr_ready", 32'(wr_ready), 32'd1);
    chk("post_reset.clr_busy", 32'(clr_busy), 32'd0);
    @(posedge clk); #1;
    tick("post_reset_idle");

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      D        = 32'($urandom);
      wr_sel   = 3'($urandom_range(0, 7));
      wr_valid = 1'($urandom_range(0, 1));
      clr_req  = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_bank_8x4
`default_nettype wire
